// File: rtl/tmds_pkg.sv
// Shared TMDS constants and helpers for the DVI output path.
// Holds the control tokens, the reset token and the bit counter.
package tmds_pkg;

    localparam logic [9:0] TOK_00  = 10'b1101010100;
    localparam logic [9:0] TOK_01  = 10'b0010101011;
    localparam logic [9:0] TOK_10  = 10'b0101010100;
    localparam logic [9:0] TOK_11  = 10'b1010101011;
    localparam logic [9:0] TOK_RST = TOK_00;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
        logic [9:0] t;
        unique case ({c1, c0})
            2'b00:   t = TOK_00;
            2'b01:   t = TOK_01;
            2'b10:   t = TOK_10;
            default: t = TOK_11;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS channel: transition-minimising stage, then DC-balancing stage.
// Disparity arithmetic is modulo 32; the value never leaves [-10, +10].
module tmds_channel
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] dat,
    input  logic       c0,
    input  logic       c1,
    input  logic       active,
    output logic [9:0] tmds
);

    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm_c;

    logic [8:0] qm;
    logic [3:0] n1q;
    logic       act_q;
    logic       c0_q;
    logic       c1_q;

    logic [4:0] cnt;
    logic [4:0] diff;
    logic       cnt_pos;
    logic       cnt_neg;

    always_comb begin
        logic [7:0] q;
        n1d      = popcount8(dat);
        use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !dat[0]);
        q        = 8'h00;
        q[0]     = dat[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ dat[i]) : (q[i-1] ^ dat[i]);
        end
        qm_c = {~use_xnor, q};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            qm    <= 9'h000;
            n1q   <= 4'd0;
            act_q <= 1'b0;
            c0_q  <= 1'b0;
            c1_q  <= 1'b0;
        end else begin
            qm    <= qm_c;
            n1q   <= popcount8(qm_c[7:0]);
            act_q <= active;
            c0_q  <= c0;
            c1_q  <= c1;
        end
    end

    // diff = n1q - n0q = 2*n1q - 8
    assign diff    = {n1q, 1'b0} - 5'd8;
    assign cnt_neg = cnt[4];
    assign cnt_pos = !cnt[4] && (cnt != 5'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmds <= TOK_RST;
            cnt  <= 5'd0;
        end else if (!act_q) begin
            tmds <= ctrl_token(c1_q, c0_q);
            cnt  <= 5'd0;
        end else if (cnt == 5'd0 || n1q == 4'd4) begin
            tmds <= {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt  <= qm[8] ? cnt + diff : cnt - diff;
        end else if ((cnt_pos && n1q > 4'd4) || (cnt_neg && n1q < 4'd4)) begin
            tmds <= {1'b1, qm[8], ~qm[7:0]};
            cnt  <= cnt + {3'b000, qm[8], 1'b0} - diff;
        end else begin
            tmds <= {1'b0, qm[8], qm[7:0]};
            cnt  <= cnt - {3'b000, ~qm[8], 1'b0} + diff;
        end
    end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// Grey-level pixel stream to three DVI TMDS channel words.
// Inputs are registered once, then fed to three independent channels.
module dvi_tmds_encoder
    import tmds_pkg::*;
#(
    parameter bit DEN_ACTIVE_LOW = 1'b1,
    parameter bit SYNC_INVERT    = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] dat,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       den,
    output logic [9:0] tmds_r,
    output logic [9:0] tmds_g,
    output logic [9:0] tmds_b
);

    logic [7:0] dat_q;
    logic       act_q;
    logic       hs_q;
    logic       vs_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dat_q <= 8'h00;
            act_q <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            dat_q <= dat;
            act_q <= den ^ DEN_ACTIVE_LOW;
            hs_q  <= hsync ^ SYNC_INVERT;
            vs_q  <= vsync ^ SYNC_INVERT;
        end
    end

    tmds_channel u_red (
        .clk    (clk),
        .resetn (resetn),
        .dat    (dat_q),
        .c0     (1'b0),
        .c1     (1'b0),
        .active (act_q),
        .tmds   (tmds_r)
    );

    tmds_channel u_green (
        .clk    (clk),
        .resetn (resetn),
        .dat    (dat_q),
        .c0     (1'b0),
        .c1     (1'b0),
        .active (act_q),
        .tmds   (tmds_g)
    );

    tmds_channel u_blue (
        .clk    (clk),
        .resetn (resetn),
        .dat    (dat_q),
        .c0     (hs_q),
        .c1     (vs_q),
        .active (act_q),
        .tmds   (tmds_b)
    );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed vectors, reset corner cases and a decoded pixel stream.
// Expected words are hand-computed; the stream uses a reference decoder.
module tb_dvi_tmds_encoder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] dat = 8'h00;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic       den = 1'b1;
    logic [9:0] tmds_r;
    logic [9:0] tmds_g;
    logic [9:0] tmds_b;

    int checks = 0;
    int fails = 0;

    dvi_tmds_encoder #(
        .DEN_ACTIVE_LOW (1'b1),
        .SYNC_INVERT    (1'b0)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .dat    (dat),
        .hsync  (hsync),
        .vsync  (vsync),
        .den    (den),
        .tmds_r (tmds_r),
        .tmds_g (tmds_g),
        .tmds_b (tmds_b)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       h;
        logic       v;
        logic       de;
        logic [9:0] er;
        logic [9:0] eg;
        logic [9:0] eb;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk3(input string name, input logic [9:0] er,
                        input logic [9:0] eg, input logic [9:0] eb);
        chk({name, "_r"}, tmds_r, er);
        chk({name, "_g"}, tmds_g, eg);
        chk({name, "_b"}, tmds_b, eb);
    endtask

    task automatic drive(input logic [7:0] d, input logic h, input logic v, input logic de);
        dat   = d;
        hsync = h;
        vsync = v;
        den   = de;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dec(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] o;
        d    = w[9] ? ~w[7:0] : w[7:0];
        o    = 8'h00;
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

    function automatic logic is_tok(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    function automatic logic [9:0] tok(input logic v, input logic h);
        logic [9:0] t;
        case ({v, h})
            2'b00:   t = 10'h354;
            2'b01:   t = 10'h0AB;
            2'b10:   t = 10'h154;
            default: t = 10'h2AB;
        endcase
        return t;
    endfunction

    function automatic logic [9:0] dec_word(input logic [9:0] w);
        return is_tok(w) ? 10'h3FF : {2'b00, dec(w)};
    endfunction

    logic [7:0] hd[600];
    logic       ha[600];
    logic       hh[600];
    logic       hv[600];

    initial begin
        vecs[0]  = '{8'h00, 1'b0, 1'b0, 1'b1, 10'h354, 10'h354, 10'h354};
        vecs[1]  = '{8'h5A, 1'b1, 1'b0, 1'b1, 10'h354, 10'h354, 10'h0AB};
        vecs[2]  = '{8'hC3, 1'b0, 1'b1, 1'b1, 10'h354, 10'h354, 10'h154};
        vecs[3]  = '{8'h00, 1'b1, 1'b1, 1'b1, 10'h354, 10'h354, 10'h2AB};
        vecs[4]  = '{8'h00, 1'b0, 1'b0, 1'b0, 10'h100, 10'h100, 10'h100};
        vecs[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF};
        vecs[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 10'h100, 10'h100, 10'h100};
        vecs[7]  = '{8'h00, 1'b0, 1'b0, 1'b1, 10'h354, 10'h354, 10'h354};
        vecs[8]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 10'h200, 10'h200, 10'h200};
        vecs[9]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 10'h0FF, 10'h0FF, 10'h0FF};
        vecs[10] = '{8'h10, 1'b0, 1'b0, 1'b0, 10'h1F0, 10'h1F0, 10'h1F0};
        vecs[11] = '{8'h01, 1'b0, 1'b0, 1'b0, 10'h1FF, 10'h1FF, 10'h1FF};
        vecs[12] = '{8'h01, 1'b0, 1'b0, 1'b0, 10'h300, 10'h300, 10'h300};
        vecs[13] = '{8'h55, 1'b0, 1'b0, 1'b0, 10'h133, 10'h133, 10'h133};
        vecs[14] = '{8'hAA, 1'b0, 1'b0, 1'b0, 10'h233, 10'h233, 10'h233};
        vecs[15] = '{8'h00, 1'b1, 1'b0, 1'b1, 10'h354, 10'h354, 10'h0AB};
        vecs[16] = '{8'h00, 1'b0, 1'b0, 1'b1, 10'h354, 10'h354, 10'h354};
        vecs[17] = '{8'h00, 1'b0, 1'b0, 1'b1, 10'h354, 10'h354, 10'h354};

        // reset held with random inputs
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
            chk3("rst_hold", 10'h354, 10'h354, 10'h354);
        end

        // release: two reset tokens, then the first real word
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        tick();
        chk3("rel_e1", 10'h354, 10'h354, 10'h354);
        tick();
        chk3("rel_e2", 10'h354, 10'h354, 10'h354);
        tick();
        chk3("rel_e3", 10'h100, 10'h100, 10'h100);

        drive(8'h00, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();

        // directed table, outputs lag inputs by two edges
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].d, vecs[i].h, vecs[i].v, vecs[i].de);
            tick();
            if (i >= 2) begin
                chk3($sformatf("vec%0d", i - 2), vecs[i-2].er, vecs[i-2].eg, vecs[i-2].eb);
            end
        end

        // mid-line asynchronous reset with nonzero disparity
        drive(8'h01, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        chk3("mid_pre", 10'h1FF, 10'h1FF, 10'h1FF);
        #5 resetn = 1'b0;
        #1;
        chk3("mid_async", 10'h354, 10'h354, 10'h354);
        tick();
        chk3("mid_held", 10'h354, 10'h354, 10'h354);
        resetn = 1'b1;
        tick();
        chk3("mid_e1", 10'h354, 10'h354, 10'h354);
        tick();
        chk3("mid_e2", 10'h354, 10'h354, 10'h354);
        tick();
        chk3("mid_e3", 10'h1FF, 10'h1FF, 10'h1FF);

        drive(8'h00, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();

        // line-structured stream checked with a reference decoder
        for (int k = 0; k < 600; k++) begin
            int p;
            p = k % 50;
            ha[k] = (p < 36);
            hh[k] = (p >= 40 && p < 44);
            hv[k] = (k >= 500 && k < 510);
            hd[k] = (k >= 150 && k < 400) ? 8'hFF : 8'($urandom);
            drive(hd[k], hh[k], hv[k], ~ha[k]);
            tick();
            if (k >= 2) begin
                if (ha[k-2]) begin
                    chk("dec_r", dec_word(tmds_r), {2'b00, hd[k-2]});
                    chk("dec_g", dec_word(tmds_g), {2'b00, hd[k-2]});
                    chk("dec_b", dec_word(tmds_b), {2'b00, hd[k-2]});
                end else begin
                    chk("blk_r", tmds_r, 10'h354);
                    chk("blk_g", tmds_g, 10'h354);
                    chk("blk_b", tmds_b, tok(hv[k-2], hh[k-2]));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
